wb_arbiter: RTL and testbench

Write-back arbiter between the execution units and the reorder buffer's result ports. N_REQ functional-unit requesters each offer one result (data + ROB tag) under a valid/ready handshake. Up to two results per cycle are granted and broadcast, registered, on two write-back ports. Those ports drive the ROB write ports and the dispatcher bypass network.

---
 rtl/wb_arbiter_pkg.sv | 30 +++
 rtl/wb_arbiter_if.sv | 36 +++
 rtl/wb_arbiter_pick.sv | 66 ++++++
 rtl/wb_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, tag encoding and requester indices for the
// write-back arbiter. Tags carry one extra MSB above the ROB index so that
// TAG_FREE (MSB set, index 0) can never collide with a real ROB slot.
package wb_arbiter_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_SIZE   = 16;
  localparam int ROB_SEL    = $clog2(ROB_SIZE);
  localparam int TAG_WIDTH  = ROB_SEL + 1;
  localparam logic [TAG_WIDTH-1:0] TAG_FREE = {1'b1, {ROB_SEL{1'b0}}};

  // ROB index field inside a tag
  localparam int CUT_LO = 0;
  localparam int CUT_HI = ROB_SEL - 1;

  localparam int N_REQ = 4;
  localparam int PTR_W = $clog2(N_REQ);

  localparam int REQ_ALU1 = 0;
  localparam int REQ_ALU2 = 1;
  localparam int REQ_LS   = 2;
  localparam int REQ_BR   = 3;

  typedef logic [PTR_W-1:0]   req_idx_t;
  typedef logic [ROB_SEL-1:0] rob_idx_t;

  // Successor of a requester index, wrapping at N_REQ.
  function automatic req_idx_t next_idx(input req_idx_t idx);
    return (int'(idx) == N_REQ - 1) ? '0 : idx + req_idx_t'(1);
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: requester-side result handshake plus the two registered
// write-back ports. master = arbiter, slave = requesters / consumers.
//
// Handshake: a requester raises req_valid with stable req_data/req_tag and
// holds them until a cycle where req_valid && req_ready (sampled at the rising
// edge) completes the transfer. req_ready is combinational and may be 0 for
// any number of cycles; req_valid must never depend on req_ready.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic [N_REQ*TAG_WIDTH-1:0]  req_tag;
  logic [N_REQ-1:0]            req_ready;

  logic                  wb_en_1;
  logic [DATA_WIDTH-1:0] wb_data_1;
  logic [TAG_WIDTH-1:0]  wb_tag_1;
  logic                  wb_en_2;
  logic [DATA_WIDTH-1:0] wb_data_2;
  logic [TAG_WIDTH-1:0]  wb_tag_2;

  modport master (
    input  req_valid, req_data, req_tag,
    output req_ready,
    output wb_en_1, wb_data_1, wb_tag_1,
    output wb_en_2, wb_data_2, wb_tag_2
  );

  modport slave (
    output req_valid, req_data, req_tag,
    input  req_ready,
    input  wb_en_1, wb_data_1, wb_tag_1,
    input  wb_en_2, wb_data_2, wb_tag_2
  );
endinterface

// File: rtl/wb_arbiter_pick.sv
// wb_arbiter_pick (the wb_pick selector): purely combinational choice of up
// to two requesters from an eligibility vector.
// Build option WB_AGE_PRIO_EN: select by smallest ROB age (ties to the lower
// index) instead of round-robin from i_rr_ptr.
module wb_arbiter_pick
  import wb_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] i_valid,
`ifdef WB_AGE_PRIO_EN
  input  rob_idx_t         i_age [N_REQ],
`else
  input  req_idx_t         i_rr_ptr,
`endif
  output req_idx_t         o_first_idx,
  output logic             o_first_hit,
  output req_idx_t         o_second_idx,
  output logic             o_second_hit
);

`ifdef WB_AGE_PRIO_EN
  // Oldest two eligible requesters; strict '<' keeps the lower index on ties.
  always_comb begin
    o_first_idx  = '0;
    o_first_hit  = 1'b0;
    o_second_idx = '0;
    o_second_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_valid[i]) begin
        if (!o_first_hit || (i_age[i] < i_age[o_first_idx])) begin
          o_second_hit = o_first_hit;
          o_second_idx = o_first_idx;
          o_first_hit  = 1'b1;
          o_first_idx  = req_idx_t'(i);
        end else if (!o_second_hit || (i_age[i] < i_age[o_second_idx])) begin
          o_second_hit = 1'b1;
          o_second_idx = req_idx_t'(i);
        end
      end
    end
  end
`else
  req_idx_t w_pos;

  // First two eligible requesters scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  always_comb begin
    o_first_idx  = '0;
    o_first_hit  = 1'b0;
    o_second_idx = '0;
    o_second_hit = 1'b0;
    w_pos        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = req_idx_t'((int'(i_rr_ptr) + k) % N_REQ);
      if (i_valid[w_pos]) begin
        if (!o_first_hit) begin
          o_first_hit = 1'b1;
          o_first_idx = w_pos;
        end else if (!o_second_hit) begin
          o_second_hit = 1'b1;
          o_second_idx = w_pos;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: grants up to two of N_REQ functional-unit results per cycle and
// broadcasts them, registered, on two write-back ports feeding the ROB and
// the bypass network. rdy=0 freezes everything; clear flushes the ports.
// Build option WB_AGE_PRIO_EN: oldest-first selection relative to com_ptr;
// without it selection is round-robin and com_ptr is ignored.
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  input  rob_idx_t     com_ptr,
  wb_arbiter_if.master bus,
  output req_idx_t     o_rr_ptr
);

  req_idx_t              r_rr_ptr;
  logic                  r_en_1;
  logic                  r_en_2;
  logic [DATA_WIDTH-1:0] r_data_1;
  logic [DATA_WIDTH-1:0] r_data_2;
  logic [TAG_WIDTH-1:0]  r_tag_1;
  logic [TAG_WIDTH-1:0]  r_tag_2;

  logic [N_REQ-1:0]      w_elig;
  logic                  w_active;
  req_idx_t              w_idx_1;
  req_idx_t              w_idx_2;
  logic                  w_hit_1;
  logic                  w_hit_2;
  logic                  w_grant_1;
  logic                  w_grant_2;
  logic [DATA_WIDTH-1:0] w_data_1;
  logic [DATA_WIDTH-1:0] w_data_2;
  logic [TAG_WIDTH-1:0]  w_tag_1;
  logic [TAG_WIDTH-1:0]  w_tag_2;

  // A valid offer carrying the free tag is not a real result.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_elig[i] = bus.req_valid[i] &&
                  (bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH] != TAG_FREE);
    end
  end

  // Grants only in a live, enabled, non-flushing cycle.
  assign w_active = rst && rdy && !clear;

`ifdef WB_AGE_PRIO_EN
  rob_idx_t w_age [N_REQ];

  // Age = distance from the commit pointer, wrapping modulo the ROB size.
  always_comb begin
    w_age = '{default: '0};
    for (int i = 0; i < N_REQ; i++) begin
      w_age[i] = bus.req_tag[i*TAG_WIDTH + CUT_LO +: (CUT_HI - CUT_LO + 1)] - com_ptr;
    end
  end
`else
  logic w_unused_com;
  assign w_unused_com = ^com_ptr;
`endif

  wb_arbiter_pick u_pick (
    .i_valid      (w_elig),
`ifdef WB_AGE_PRIO_EN
    .i_age        (w_age),
`else
    .i_rr_ptr     (r_rr_ptr),
`endif
    .o_first_idx  (w_idx_1),
    .o_first_hit  (w_hit_1),
    .o_second_idx (w_idx_2),
    .o_second_hit (w_hit_2)
  );

  assign w_grant_1 = w_active && w_hit_1;
  assign w_grant_2 = w_active && w_hit_2;

  assign w_data_1 = bus.req_data[int'(w_idx_1)*DATA_WIDTH +: DATA_WIDTH];
  assign w_data_2 = bus.req_data[int'(w_idx_2)*DATA_WIDTH +: DATA_WIDTH];
  assign w_tag_1  = bus.req_tag[int'(w_idx_1)*TAG_WIDTH +: TAG_WIDTH];
  assign w_tag_2  = bus.req_tag[int'(w_idx_2)*TAG_WIDTH +: TAG_WIDTH];

  // Ready goes only to the (at most two) granted requesters.
  always_comb begin
    bus.req_ready = '0;
    if (w_grant_1) bus.req_ready[w_idx_1] = 1'b1;
    if (w_grant_2) bus.req_ready[w_idx_2] = 1'b1;
  end

  // Write-back port registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_1   <= 1'b0;
      r_en_2   <= 1'b0;
      r_data_1 <= '0;
      r_data_2 <= '0;
      r_tag_1  <= TAG_FREE;
      r_tag_2  <= TAG_FREE;
      r_rr_ptr <= '0;
    end else if (clear) begin
      // Data is left as-is: with en=0 and a free tag nothing consumes it.
      r_en_1   <= 1'b0;
      r_en_2   <= 1'b0;
      r_tag_1  <= TAG_FREE;
      r_tag_2  <= TAG_FREE;
      r_rr_ptr <= '0;
    end else if (rdy) begin
      r_en_1 <= w_grant_1;
      r_en_2 <= w_grant_2;
      if (w_grant_1) begin
        r_data_1 <= w_data_1;
        r_tag_1  <= w_tag_1;
      end
      if (w_grant_2) begin
        r_data_2 <= w_data_2;
        r_tag_2  <= w_tag_2;
      end
      // Port 2 is always the later pick, so it sets the next start point.
      if (w_grant_2) begin
        r_rr_ptr <= next_idx(w_idx_2);
      end else if (w_grant_1) begin
        r_rr_ptr <= next_idx(w_idx_1);
      end
    end
  end

  assign bus.wb_en_1   = r_en_1;
  assign bus.wb_data_1 = r_data_1;
  assign bus.wb_tag_1  = r_tag_1;
  assign bus.wb_en_2   = r_en_2;
  assign bus.wb_data_2 = r_data_2;
  assign bus.wb_tag_2  = r_tag_2;
  assign o_rr_ptr      = r_rr_ptr;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: vector table, directed corner sequences and random traffic
// against a list-based reference of the write-back arbitration rules.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int SB_W = DATA_WIDTH + TAG_WIDTH;
  localparam logic [TAG_WIDTH-1:0] TF = TAG_FREE;

  logic     clk;
  logic     rst;
  logic     rdy;
  logic     clear;
  rob_idx_t com_ptr;
  req_idx_t rr_ptr;

  wb_arbiter_if bus();

  wb_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .clear   (clear),
    .com_ptr (com_ptr),
    .bus     (bus.master),
    .o_rr_ptr(rr_ptr)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver state ----------------
  logic [N_REQ-1:0]      drv_valid;
  logic [DATA_WIDTH-1:0] drv_data [N_REQ];
  logic [TAG_WIDTH-1:0]  drv_tag  [N_REQ];

  // ---------------- reference model state ----------------
  int                    m_rr;
  logic                  m_en1, m_en2, m_loaded;
  logic [DATA_WIDTH-1:0] m_data1, m_data2;
  logic [TAG_WIDTH-1:0]  m_tag1, m_tag2;
  logic [SB_W-1:0]       exp_q[$];

  int                    n_checks;
  int                    n_errors;
  logic [N_REQ-1:0]      obs_ready;
  int                    last_g1, last_g2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] = drv_data[i];
      bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH]    = drv_tag[i];
    end
    bus.req_valid = drv_valid;
  endtask

  task automatic model_reset();
    m_rr = 0; m_en1 = 0; m_en2 = 0; m_loaded = 0;
    m_data1 = '0; m_data2 = '0; m_tag1 = TF; m_tag2 = TF;
    exp_q.delete();
  endtask

  function automatic int age_of(input int i);
    return ((int'(drv_tag[i]) % ROB_SIZE) - int'(com_ptr) + ROB_SIZE) % ROB_SIZE;
  endfunction

  // Eligible requesters listed in rotated order (or sorted by age*N+index),
  // first two entries win.
  task automatic model_pick(output logic [N_REQ-1:0] er, output int g1, output int g2);
    int order[$];
    er = '0; g1 = -1; g2 = -1;
    if (rst && rdy && !clear) begin
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (m_rr + k) % N_REQ;
        if (drv_valid[i] && drv_tag[i] != TF) begin
`ifdef WB_AGE_PRIO_EN
          order.push_back(age_of(i) * N_REQ + i);
`else
          order.push_back(i);
`endif
        end
      end
`ifdef WB_AGE_PRIO_EN
      order.sort();
`endif
      if (order.size() > 0) begin g1 = order[0] % N_REQ; er[g1] = 1'b1; end
      if (order.size() > 1) begin g2 = order[1] % N_REQ; er[g2] = 1'b1; end
    end
  endtask

  task automatic model_edge(input int g1, input int g2);
    m_loaded = 1'b0;
    if (clear) begin
      m_en1 = 0; m_en2 = 0; m_tag1 = TF; m_tag2 = TF; m_rr = 0;
    end else if (rdy) begin
      m_loaded = 1'b1;
      m_en1 = (g1 >= 0);
      m_en2 = (g2 >= 0);
      if (g1 >= 0) begin
        m_data1 = drv_data[g1]; m_tag1 = drv_tag[g1];
        exp_q.push_back({drv_tag[g1], drv_data[g1]});
        m_rr = (g1 + 1) % N_REQ;
      end
      if (g2 >= 0) begin
        m_data2 = drv_data[g2]; m_tag2 = drv_tag[g2];
        exp_q.push_back({drv_tag[g2], drv_data[g2]});
        m_rr = (g2 + 1) % N_REQ;
      end
    end
  endtask

  task automatic sb_pop(input string name, input logic [SB_W-1:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got write %0h expected none", name, act);
    end else begin
      chk(name, act, exp_q.pop_front());
    end
  endtask

  task automatic check_outputs();
    chk("wb_en_1",   bus.wb_en_1,   m_en1);
    chk("wb_en_2",   bus.wb_en_2,   m_en2);
    chk("wb_tag_1",  bus.wb_tag_1,  m_tag1);
    chk("wb_tag_2",  bus.wb_tag_2,  m_tag2);
    chk("wb_data_1", bus.wb_data_1, m_data1);
    chk("wb_data_2", bus.wb_data_2, m_data2);
    chk("rr_ptr",    rr_ptr,        m_rr);
    if (m_loaded) begin
      if (bus.wb_en_1) sb_pop("sb_port1", {bus.wb_tag_1, bus.wb_data_1});
      if (bus.wb_en_2) sb_pop("sb_port2", {bus.wb_tag_2, bus.wb_data_2});
    end
  endtask

  // One clock: drive at negedge, check ready, edge, check registered ports.
  task automatic cycle();
    logic [N_REQ-1:0] er;
    int g1, g2;
    apply();
    #1;
    model_pick(er, g1, g2);
    obs_ready = bus.req_ready;
    chk("req_ready", bus.req_ready, er);
    last_g1 = g1;
    last_g2 = g2;
    @(posedge clk);
    model_edge(g1, g2);
    @(negedge clk);
    check_outputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N_REQ-1:0]     valid;
    logic [TAG_WIDTH-1:0] tag [N_REQ];
    logic                 rdy;
    logic                 clear;
    logic [N_REQ-1:0]     exp_ready;
    logic                 exp_en1;
    logic [TAG_WIDTH-1:0] exp_tag1;
    logic                 exp_en2;
    logic [TAG_WIDTH-1:0] exp_tag2;
    int                   exp_rr;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input int t0, input int t1, input int t2,
                              input int t3, input logic r, input logic c, input logic [3:0] er,
                              input logic e1, input int tg1, input logic e2, input int tg2,
                              input int err);
    vec_t x;
    x.valid = v;
    x.tag[0] = TAG_WIDTH'(t0); x.tag[1] = TAG_WIDTH'(t1);
    x.tag[2] = TAG_WIDTH'(t2); x.tag[3] = TAG_WIDTH'(t3);
    x.rdy = r; x.clear = c; x.exp_ready = er;
    x.exp_en1 = e1; x.exp_tag1 = TAG_WIDTH'(tg1);
    x.exp_en2 = e2; x.exp_tag2 = TAG_WIDTH'(tg2);
    x.exp_rr = err;
    return x;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    drv_valid = '0;
    apply();
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  // ---------------- main ----------------
  logic [N_REQ-1:0] pend;

  initial begin
    vec_t vecs[$];
    int   F;
    F = int'(TF);
    n_checks = 0; n_errors = 0;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; com_ptr = '0;
    drv_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin drv_data[i] = '0; drv_tag[i] = '0; end
    apply();
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, '0);
    check_outputs();
    rst = 1'b1;

`ifndef WB_AGE_PRIO_EN
    vecs.push_back(mk(4'b1111, 1, 2, 3, 4,   1, 0, 4'b0011, 1, 1, 1, 2, 2));
    vecs.push_back(mk(4'b1111, 5, 6, 3, 4,   1, 0, 4'b1100, 1, 3, 1, 4, 0));
    vecs.push_back(mk(4'b0100, 0, 0, 5, 0,   1, 0, 4'b0100, 1, 5, 0, 4, 3));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 0,   1, 0, 4'b0000, 0, 5, 0, 4, 3));
    vecs.push_back(mk(4'b1001, 7, 0, 0, 8,   0, 0, 4'b0000, 0, 5, 0, 4, 3));
    vecs.push_back(mk(4'b1001, 7, 0, 0, 8,   0, 0, 4'b0000, 0, 5, 0, 4, 3));
    vecs.push_back(mk(4'b1001, 7, 0, 0, 8,   0, 0, 4'b0000, 0, 5, 0, 4, 3));
    vecs.push_back(mk(4'b1001, 7, 0, 0, 8,   1, 0, 4'b1001, 1, 8, 1, 7, 1));
    vecs.push_back(mk(4'b0111, 1, 2, 3, 0,   1, 1, 4'b0000, 0, F, 0, F, 0));
    vecs.push_back(mk(4'b0111, 1, 2, 3, 0,   1, 0, 4'b0011, 1, 1, 1, 2, 2));
    vecs.push_back(mk(4'b0100, 0, 0, F, 0,   1, 0, 4'b0000, 0, 1, 0, 2, 2));
    vecs.push_back(mk(4'b1010, 0, 9, 0, 10,  1, 0, 4'b1010, 1, 10, 1, 9, 2));
    vecs.push_back(mk(4'b0011, F, 11, 0, 0,  1, 0, 4'b0010, 1, 11, 0, 9, 2));
    vecs.push_back(mk(4'b1111, 1, 2, 3, 4,   0, 1, 4'b0000, 0, F, 0, F, 0));

    for (int v = 0; v < vecs.size(); v++) begin
      drv_valid = vecs[v].valid;
      for (int i = 0; i < N_REQ; i++) begin
        drv_tag[i]  = vecs[v].tag[i];
        drv_data[i] = 32'hD000_0000 + 32'(i * 256) + 32'(vecs[v].tag[i]);
      end
      rdy = vecs[v].rdy;
      clear = vecs[v].clear;
      cycle();
      chk($sformatf("vec%0d_ready", v), obs_ready, vecs[v].exp_ready);
      chk($sformatf("vec%0d_en1", v), bus.wb_en_1, vecs[v].exp_en1);
      chk($sformatf("vec%0d_tag1", v), bus.wb_tag_1, vecs[v].exp_tag1);
      chk($sformatf("vec%0d_en2", v), bus.wb_en_2, vecs[v].exp_en2);
      chk($sformatf("vec%0d_tag2", v), bus.wb_tag_2, vecs[v].exp_tag2);
      chk($sformatf("vec%0d_rr", v), rr_ptr, vecs[v].exp_rr);
    end
    rdy = 1'b1; clear = 1'b0;
`endif

    // Only the LS unit valid: single grant on port 1, pulse lasts one cycle.
    do_reset();
    drv_valid = '0;
    drv_valid[REQ_LS] = 1'b1;
    drv_tag[REQ_LS] = 5;
    drv_data[REQ_LS] = 32'hDEADBEEF;
    cycle();
    chk("ls_ready", obs_ready, 4'b0100);
    chk("ls_en1", bus.wb_en_1, 1'b1);
    chk("ls_tag1", bus.wb_tag_1, 5);
    chk("ls_data1", bus.wb_data_1, 32'hDEADBEEF);
    chk("ls_en2", bus.wb_en_2, 1'b0);
    chk("ls_rr", rr_ptr, 3);
    drv_valid = '0;
    cycle();
    chk("ls_pulse_end", bus.wb_en_1, 1'b0);

    // Async reset between edges while grants are live.
    drv_valid = 4'b1111;
    drv_tag[REQ_ALU1] = 1; drv_tag[REQ_ALU2] = 2; drv_tag[REQ_LS] = 3; drv_tag[REQ_BR] = 4;
    cycle();
    apply();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_en1", bus.wb_en_1, 1'b0);
    chk("arst_en2", bus.wb_en_2, 1'b0);
    chk("arst_tag1", bus.wb_tag_1, TF);
    chk("arst_tag2", bus.wb_tag_2, TF);
    chk("arst_data1", bus.wb_data_1, '0);
    chk("arst_ready", bus.req_ready, '0);
    chk("arst_rr", rr_ptr, 0);
    @(negedge clk);
    model_reset();
    rst = 1'b1;

`ifdef WB_AGE_PRIO_EN
    // Oldest-first relative to commit pointer 14 with wrap-around.
    com_ptr = 14;
    drv_valid = 4'b1111;
    drv_tag[0] = 3; drv_tag[1] = 15; drv_tag[2] = 14; drv_tag[3] = 0;
    cycle();
    chk("age_ready", obs_ready, 4'b0110);
    chk("age_tag1", bus.wb_tag_1, 14);
    chk("age_tag2", bus.wb_tag_2, 15);
    chk("age_rr", rr_ptr, 2);
    drv_valid = 4'b1001;
    cycle();
    chk("age2_ready", obs_ready, 4'b1001);
    chk("age2_tag1", bus.wb_tag_1, 0);
    chk("age2_tag2", bus.wb_tag_2, 3);
    drv_valid = '0;
    cycle();
`endif

    // Random traffic obeying the requester hold rule.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 60) begin
          pend[i] = 1'b1;
          drv_tag[i] = TAG_WIDTH'($urandom_range(0, ROB_SIZE));
          drv_data[i] = $urandom;
        end else if (pend[i] && drv_tag[i] == TF && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b0;
        end
      end
      drv_valid = pend;
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 19) == 0);
      com_ptr = rob_idx_t'($urandom_range(0, ROB_SIZE - 1));
      cycle();
      if (last_g1 >= 0) pend[last_g1] = 1'b0;
      if (last_g2 >= 0) pend[last_g2] = 1'b0;
      if (clear) pend = '0;
    end
    clear = 1'b0; rdy = 1'b1; drv_valid = '0;
    cycle();

    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
